// File: rtl/reg_bus_arbiter_if.sv
// Requester and component-bus signals of the register bus arbiter.
// The arbiter uses the slave view; the requesters and components use the master view.
interface reg_bus_arbiter_if #(
    parameter int N_REQ  = 2,
    parameter int N_COMP = 32
);
    logic [N_REQ-1:0]     req_valid;
    logic [N_REQ-1:0]     req_write;
    logic [8*N_REQ-1:0]   req_comp;
    logic [8*N_REQ-1:0]   req_addr;
    logic [32*N_REQ-1:0]  req_wdata;
    logic [N_REQ-1:0]     req_ready;
    logic [N_REQ-1:0]     resp_valid;
    logic [N_REQ-1:0]     resp_ready;
    logic [31:0]          resp_rdata;
    logic                 resp_err;
    logic [15:0]          reg_bus_waddr;
    logic [31:0]          reg_bus_wdata;
    logic [N_COMP-1:0]    reg_bus_wvalid;
    logic [15:0]          reg_bus_araddr;
    logic [N_COMP-1:0]    reg_bus_arvalid;
    logic [N_COMP-1:0]    reg_bus_rvalid;
    logic [32*N_COMP-1:0] reg_bus_rdata;

    modport slave (
        input  req_valid, req_write, req_comp, req_addr, req_wdata, resp_ready,
        input  reg_bus_rvalid, reg_bus_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output reg_bus_waddr, reg_bus_wdata, reg_bus_wvalid, reg_bus_araddr, reg_bus_arvalid
    );

    modport master (
        output req_valid, req_write, req_comp, req_addr, req_wdata, resp_ready,
        output reg_bus_rvalid, reg_bus_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  reg_bus_waddr, reg_bus_wdata, reg_bus_wvalid, reg_bus_araddr, reg_bus_arvalid
    );
endinterface

// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter sharing one component register bus between N_REQ masters,
// one transaction at a time, with a bounded wait on every read.
module reg_bus_arbiter #(
    parameter int         N_REQ    = 2,
    parameter int         N_COMP   = 32,
    parameter logic [7:0] BCAST_ID = 8'hFF,
    parameter int         TIMEOUT  = 1024
) (
    input logic              clk,
    input logic              rst,
    reg_bus_arbiter_if.slave bus
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {IDLE, WR, RD_REQ, RD_WAIT, RESP} state_t;

    state_t            state_q;
    logic [PW-1:0]     rr_ptr_q;
    logic [PW-1:0]     owner_q;
    logic [7:0]        comp_q;
    logic [7:0]        addr_q;
    logic [31:0]       wdata_q;
    logic [TW-1:0]     cnt_q;
    logic [N_COMP-1:0] wvalid_q;
    logic [N_COMP-1:0] arvalid_q;
    logic [N_REQ-1:0]  resp_valid_q;
    logic [31:0]       rdata_q;
    logic              err_q;

    logic              any_d;
    logic [PW-1:0]     win_d;
    logic              win_write_d;
    logic [7:0]        win_comp_d;
    logic [7:0]        win_addr_d;
    logic [31:0]       win_wdata_d;
    logic              rvalid_sel_d;
    logic [31:0]       rdata_sel_d;

    function automatic logic [N_REQ-1:0] req_onehot(input logic [PW-1:0] idx);
        req_onehot = '0;
        for (int i = 0; i < N_REQ; i++)
            req_onehot[i] = (idx == PW'(i));
    endfunction

    function automatic logic comp_ok(input logic [7:0] c);
        return int'(c) < N_COMP;
    endfunction

    // Broadcast only widens write strobes; reads always target a single component.
    function automatic logic [N_COMP-1:0] comp_mask(input logic [7:0] c, input logic bcast_en);
        comp_mask = '0;
        for (int j = 0; j < N_COMP; j++)
            comp_mask[j] = (bcast_en && c == BCAST_ID) || (c == 8'(j));
    endfunction

    always_comb begin
        any_d       = 1'b0;
        win_d       = '0;
        win_write_d = 1'b0;
        win_comp_d  = '0;
        win_addr_d  = '0;
        win_wdata_d = '0;
        for (int k = 1; k <= N_REQ; k++)
            for (int i = 0; i < N_REQ; i++)
                if (!any_d && bus.req_valid[i] && i == (int'(rr_ptr_q) + k) % N_REQ) begin
                    any_d = 1'b1;
                    win_d = PW'(i);
                end
        for (int i = 0; i < N_REQ; i++)
            if (win_d == PW'(i)) begin
                win_write_d = bus.req_write[i];
                win_comp_d  = bus.req_comp[i*8 +: 8];
                win_addr_d  = bus.req_addr[i*8 +: 8];
                win_wdata_d = bus.req_wdata[i*32 +: 32];
            end
    end

    // Only the addressed component's rvalid/rdata are observed.
    always_comb begin
        rvalid_sel_d = 1'b0;
        rdata_sel_d  = '0;
        for (int j = 0; j < N_COMP; j++)
            if (comp_q == 8'(j)) begin
                rvalid_sel_d = bus.reg_bus_rvalid[j];
                rdata_sel_d  = bus.reg_bus_rdata[j*32 +: 32];
            end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rr_ptr_q     <= PW'(N_REQ - 1);
            owner_q      <= '0;
            comp_q       <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            wvalid_q     <= '0;
            arvalid_q    <= '0;
            resp_valid_q <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (any_d) begin
                    owner_q  <= win_d;
                    rr_ptr_q <= win_d;
                    comp_q   <= win_comp_d;
                    addr_q   <= win_addr_d;
                    wdata_q  <= win_wdata_d;
                    if (win_write_d) begin
                        state_q  <= WR;
                        wvalid_q <= comp_mask(win_comp_d, 1'b1);
                    end else if (comp_ok(win_comp_d)) begin
                        state_q   <= RD_REQ;
                        arvalid_q <= comp_mask(win_comp_d, 1'b0);
                    end else begin
                        state_q      <= RESP;
                        resp_valid_q <= req_onehot(win_d);
                        rdata_q      <= 32'hDEADBEEF;
                        err_q        <= 1'b1;
                    end
                end
                WR: begin
                    wvalid_q     <= '0;
                    resp_valid_q <= req_onehot(owner_q);
                    rdata_q      <= '0;
                    err_q        <= !comp_ok(comp_q) && (comp_q != BCAST_ID);
                    state_q      <= RESP;
                end
                RD_REQ: begin
                    arvalid_q <= '0;
                    cnt_q     <= '0;
                    state_q   <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (rvalid_sel_d) begin
                        rdata_q      <= rdata_sel_d;
                        err_q        <= 1'b0;
                        resp_valid_q <= req_onehot(owner_q);
                        state_q      <= RESP;
                    end else if (cnt_q == TW'(TIMEOUT - 1)) begin
                        rdata_q      <= 32'hFFFFFFFF;
                        err_q        <= 1'b1;
                        resp_valid_q <= req_onehot(owner_q);
                        state_q      <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: if (|(bus.resp_ready & resp_valid_q)) begin
                    resp_valid_q <= '0;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Grant is combinational so a held request is accepted in its IDLE cycle.
    assign bus.req_ready       = (!rst && state_q == IDLE && any_d) ? req_onehot(win_d) : '0;
    assign bus.resp_valid      = resp_valid_q;
    assign bus.resp_rdata      = rdata_q;
    assign bus.resp_err        = err_q;
    assign bus.reg_bus_waddr   = {8'b0, addr_q};
    assign bus.reg_bus_araddr  = {8'b0, addr_q};
    assign bus.reg_bus_wdata   = wdata_q;
    assign bus.reg_bus_wvalid  = wvalid_q;
    assign bus.reg_bus_arvalid = arvalid_q;
endmodule
